// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants and FSM state type for the NTT coefficient loader
package ntt_pkg;

    localparam int KYBER_Q = 3329;
    localparam int N_COEF  = 256;
    localparam int COEF_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/coef_rangechk.sv
// rtl/coef_rangechk.sv - one-lane conditional subtraction of Q, flags values at or above 2Q
module coef_rangechk
    import ntt_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  logic [COEF_W-1:0] c,
    output logic [COEF_W-1:0] r,
    output logic              over
);

    localparam logic [COEF_W:0]   Q1  = (COEF_W+1)'(Q);
    localparam logic [COEF_W:0]   Q2  = (COEF_W+1)'(2 * Q);
    localparam logic [COEF_W-1:0] QW  = COEF_W'(Q);

    logic [COEF_W:0] cx;

    assign cx = {1'b0, c};

    // values in [Q, 2Q) fold down once; anything larger passes through and is flagged
    always_comb begin
        over = (cx >= Q2);
        r    = c;
        if (cx >= Q1 && !over) begin
            r = c - QW;
        end
    end

endmodule

// File: rtl/ntt_loader.sv
// rtl/ntt_loader.sv - streams coefficient pairs into the NTT core RAM; NTT_LOADER_RANGECHK_EN enables reduction and err
module ntt_loader
    import ntt_pkg::*;
#(
    parameter int Q     = KYBER_Q,
    parameter int NPAIR = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic        mode_in,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    input  logic        init_done,
    input  logic        done,
    output logic        start,
    output logic        we,
    output logic [7:0]  address_ina,
    output logic [7:0]  address_inb,
    output logic [15:0] data_ina,
    output logic [15:0] data_inb,
    output logic        mode,
    output logic        busy,
    output logic        load_done,
    output logic        err
);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        k;
    logic              hs;
    logic [COEF_W-1:0] coef_a;
    logic [COEF_W-1:0] coef_b;

    assign s_ready = (state == LOAD) && (int'(k) < NPAIR);
    assign hs      = s_valid && s_ready;
    assign busy    = (state != IDLE);

`ifdef NTT_LOADER_RANGECHK_EN
    logic over_a;
    logic over_b;
    logic err_q;

    coef_rangechk #(.Q(Q)) u_rangechk_a (.c(s_data[15:0]),  .r(coef_a), .over(over_a));
    coef_rangechk #(.Q(Q)) u_rangechk_b (.c(s_data[31:16]), .r(coef_b), .over(over_b));

    // sticky out-of-range flag, cleared only by a new accepted load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && load_req) begin
            err_q <= 1'b0;
        end else if (hs && (over_a || over_b)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign coef_a = s_data[15:0];
    assign coef_b = s_data[31:16];
    assign err    = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: load on request, flush after the last pair, run until the core reports done
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_req) state_nxt = LOAD;
            LOAD:    if (hs && int'(k) == NPAIR - 1) state_nxt = FLUSH;
            FLUSH:   if (init_done) state_nxt = RUN;
            RUN:     if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // registered core-facing outputs: one RAM write per accepted pair, start held through the load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k           <= '0;
            start       <= 1'b0;
            we          <= 1'b0;
            address_ina <= '0;
            address_inb <= '0;
            data_ina    <= '0;
            data_inb    <= '0;
            mode        <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            we        <= 1'b0;
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_req) begin
                        mode  <= mode_in;
                        k     <= '0;
                        start <= 1'b1;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        we          <= 1'b1;
                        address_ina <= {k[6:0], 1'b0};
                        address_inb <= {k[6:0], 1'b1};
                        data_ina    <= coef_a;
                        data_inb    <= coef_b;
                        k           <= k + 8'd1;
                    end
                end
                FLUSH: begin
                    if (init_done) begin
                        start     <= 1'b0;
                        load_done <= 1'b1;
                    end
                end
                RUN: begin
                    start <= 1'b0;
                end
                default: begin
                    start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_loader.sv
// tb/tb_ntt_loader.sv - randomized self-checking bench for ntt_loader against a write-queue and RAM model
module tb_ntt_loader;

    localparam int Q     = 3329;
    localparam int NPAIR = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic        mode_in;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        init_done;
    logic        done;
    logic        start;
    logic        we;
    logic [7:0]  address_ina;
    logic [7:0]  address_inb;
    logic [15:0] data_ina;
    logic [15:0] data_inb;
    logic        mode;
    logic        busy;
    logic        load_done;
    logic        err;

    always #5 clk = ~clk;

    ntt_loader #(.Q(Q), .NPAIR(NPAIR)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_req    (load_req),
        .mode_in     (mode_in),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .init_done   (init_done),
        .done        (done),
        .start       (start),
        .we          (we),
        .address_ina (address_ina),
        .address_inb (address_inb),
        .data_ina    (data_ina),
        .data_inb    (data_inb),
        .mode        (mode),
        .busy        (busy),
        .load_done   (load_done),
        .err         (err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] da;
        logic [15:0] db;
        logic        bad;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] ram_obs [256];
    logic [15:0] ram_exp [256];
    bit          err_exp;
    logic [7:0]  last_a;
    logic [7:0]  last_b;
    logic [15:0] last_da;
    logic [15:0] last_db;
    int          kk;

    function automatic logic [15:0] red(input logic [15:0] c);
`ifdef NTT_LOADER_RANGECHK_EN
        if (int'(c) >= Q && int'(c) < 2 * Q) return c - 16'(Q);
`endif
        return c;
    endfunction

    function automatic bit is_bad(input logic [15:0] c);
`ifdef NTT_LOADER_RANGECHK_EN
        return int'(c) >= 2 * Q;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] gen(input int src, input int idx);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'(2 * idx);
        hi = 16'(2 * idx + 1);
        if (src == 1) return $urandom;
        if (src == 2 && idx == 0) return {16'd3329, 16'd3328};
        if (src == 2 && idx == 1) return {16'd5, 16'd7000};
        return {hi, lo};
    endfunction

    // write monitor: every write must match the next queued expectation; idle cycles must hold
    always @(negedge clk) begin : mon
        wr_t w;
        if (rst) begin
            last_a  = 8'd0;
            last_b  = 8'd0;
            last_da = 16'd0;
            last_db = 16'd0;
        end else if (we) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write", {24'd0, address_ina}, 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                chk("wr_addr_a", address_ina, w.a);
                chk("wr_addr_b", address_inb, w.a | 8'd1);
                chk("wr_data_a", data_ina, w.da);
                chk("wr_data_b", data_inb, w.db);
                err_exp = err_exp | w.bad;
                chk("wr_err", err, err_exp);
            end
            ram_obs[address_ina] = data_ina;
            ram_obs[address_inb] = data_inb;
            last_a  = address_ina;
            last_b  = address_inb;
            last_da = data_ina;
            last_db = data_inb;
        end else begin
            chk("hold_addr_a", address_ina, last_a);
            chk("hold_addr_b", address_inb, last_b);
            chk("hold_data_a", data_ina, last_da);
            chk("hold_data_b", data_inb, last_db);
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        #2;
        rst       = 1'b1;
        load_req  = 1'b0;
        s_valid   = 1'b0;
        init_done = 1'b0;
        done      = 1'b0;
        exp_q.delete();
        kk        = 0;
        err_exp   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic start_load(input bit m, input bit with_valid);
        @(negedge clk);
        load_req = 1'b1;
        mode_in  = m;
        s_valid  = with_valid;
        s_data   = $urandom;
        kk       = 0;
        err_exp  = 1'b0;
        chk("idle_ready", s_ready, 1'b0);
        @(negedge clk);
        load_req = 1'b0;
        s_valid  = 1'b0;
        chk("load_busy", busy, 1'b1);
        chk("load_start", start, 1'b1);
        chk("load_mode", mode, m);
    endtask

    task automatic send(input int n, input int src, input int gap);
        int acc;
        int cyc;
        bit v;
        logic [31:0] d;
        wr_t w;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 2000) begin
            @(negedge clk);
            if (gap == 0)      v = 1'b1;
            else if (gap == 1) v = (cyc % 3 != 2);
            else               v = ($urandom_range(0, 3) != 0);
            d       = gen(src, acc);
            s_valid = v;
            s_data  = v ? d : $urandom;
            if (v && s_ready) begin
                w.a   = 8'(2 * kk);
                w.da  = red(d[15:0]);
                w.db  = red(d[31:16]);
                w.bad = is_bad(d[15:0]) | is_bad(d[31:16]);
                exp_q.push_back(w);
                ram_exp[2 * kk]     = w.da;
                ram_exp[2 * kk + 1] = w.db;
                acc++;
                kk++;
            end
            cyc++;
        end
        chk("send_budget", acc, n);
    endtask

    task automatic finish_load(input bit m);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = $urandom;
            chk("overrun_ready", s_ready, 1'b0);
            chk("flush_start", start, 1'b1);
            chk("flush_busy", busy, 1'b1);
            chk("flush_load_done", load_done, 1'b0);
        end
        chk("pending_writes", exp_q.size(), 0);
        chk("err_hold", err, err_exp);
        init_done = 1'b1;
        @(negedge clk);
        init_done = 1'b0;
        chk("ld_pulse", load_done, 1'b1);
        chk("run_start", start, 1'b0);
        chk("run_busy", busy, 1'b1);
        chk("run_ready", s_ready, 1'b0);
        load_req = 1'b1;
        mode_in  = ~m;
        @(negedge clk);
        load_req = 1'b0;
        chk("ld_single", load_done, 1'b0);
        chk("run_ignore_busy", busy, 1'b1);
        chk("run_ignore_start", start, 1'b0);
        chk("run_ignore_mode", mode, m);
        repeat (2) @(negedge clk);
        chk("run_wait_busy", busy, 1'b1);
        done = 1'b1;
        @(negedge clk);
        done    = 1'b0;
        s_valid = 1'b0;
        chk("idle_busy", busy, 1'b0);
        chk("idle_start", start, 1'b0);
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("ram[%0d]", i), ram_obs[i], ram_exp[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        load_req  = 1'b0;
        mode_in   = 1'b0;
        s_valid   = 1'b0;
        s_data    = 32'd0;
        init_done = 1'b0;
        done      = 1'b0;
        err_exp   = 1'b0;
        kk        = 0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_we", we, 1'b0);
        chk("rst_addr_a", address_ina, 8'd0);
        chk("rst_addr_b", address_inb, 8'd0);
        chk("rst_data", {data_inb, data_ina}, 32'd0);
        chk("rst_mode", mode, 1'b0);
        chk("rst_load_done", load_done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ready", s_ready, 1'b0);

        // back-to-back counting pattern, word offered in the same cycle as load_req
        start_load(1'b0, 1'b1);
        send(NPAIR, 0, 0);
        finish_load(1'b0);
        for (int i = 0; i < 256; i += 51) chk("ram_identity", ram_obs[i], i);

        // every third cycle idle
        start_load(1'b1, 1'b0);
        send(NPAIR, 0, 1);
        finish_load(1'b1);

        // random data, random gaps
        start_load(1'b0, 1'b0);
        send(NPAIR, 1, 2);
        finish_load(1'b0);

        // abandon a partial load, then reload from address 0
        start_load(1'b1, 1'b0);
        send(40, 1, 2);
        @(negedge clk);
        s_valid = 1'b0;
        reset_dut();
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_start", start, 1'b0);
        chk("mid_rst_addr", address_ina, 8'd0);
        chk("mid_rst_mode", mode, 1'b0);
        start_load(1'b0, 1'b0);
        send(NPAIR, 1, 2);
        finish_load(1'b0);

        // boundary coefficients 3328, 3329, 7000
        start_load(1'b1, 1'b0);
        send(NPAIR, 2, 2);
        finish_load(1'b1);
        chk("rng_3328", ram_obs[0], 16'd3328);
        chk("rng_3329", ram_obs[1], red(16'd3329));
        chk("rng_7000", ram_obs[2], 16'd7000);
        chk("rng_err_final", err, is_bad(16'd7000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
